// File: rtl/xnor_descrambler16.sv
// Streaming 16-bit XNOR descrambler with a Fibonacci LFSR keystream and a one-word output register.
// Optional pass-through input is enabled by defining XNOR_DESCRAMBLE_BYPASS_EN.
module xnor_descrambler16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef XNOR_DESCRAMBLE_BYPASS_EN
  input  logic        bypass,
`endif
  input  logic        seed_load,
  input  logic [15:0] seed_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [15:0] word_count
);

  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic        accept;
  logic        use_key;
  logic [15:0] result;

  // x^16+x^14+x^13+x^11+1 taps on bits 15, 13, 12, 10
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  assign in_ready = !seed_load && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef XNOR_DESCRAMBLE_BYPASS_EN
  assign use_key = !bypass;
`else
  assign use_key = 1'b1;
`endif

  assign result = use_key ? ~(in_data ^ lfsr) : in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr       <= SEED;
      word_count <= 16'h0000;
    end else if (seed_load) begin
      lfsr       <= (seed_in == 16'h0000) ? SEED : seed_in;
      word_count <= 16'h0000;
    end else if (accept) begin
      if (use_key) begin
        lfsr <= lfsr_next;
      end
      word_count <= word_count + 16'h0001;
    end
  end

  // The output word stays put after a drain; only out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= result;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xnor_descrambler16.sv
// Directed self-checking bench for xnor_descrambler16 with hand-computed keystream values.
// Define XNOR_DESCRAMBLE_BYPASS_EN to also exercise the bypass path.
module tb_xnor_descrambler16;

  logic        clk;
  logic        rst_n;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [15:0] word_count;
`ifdef XNOR_DESCRAMBLE_BYPASS_EN
  logic        bypass;
`endif

  int checks;
  int failures;

  xnor_descrambler16 dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef XNOR_DESCRAMBLE_BYPASS_EN
    .bypass     (bypass),
`endif
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    seed_load = 1'b0;
    seed_in   = 16'h0000;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b1;
`ifdef XNOR_DESCRAMBLE_BYPASS_EN
    bypass    = 1'b0;
`endif
    #12;
    checkOutput("rst_in_ready", {15'd0, in_ready}, 16'd1);
    checkOutput("rst_out_valid", {15'd0, out_valid}, 16'd0);
    checkOutput("rst_out_data", out_data, 16'h0000);
    checkOutput("rst_word_count", word_count, 16'h0000);
    checkOutput("rst_lfsr", dut.lfsr, 16'hACE1);
    @(negedge clk);
    rst_n = 1'b1;

    // First word with key ACE1
    in_valid = 1'b1;
    in_data  = 16'h57F6;
    #1;
    checkOutput("first_in_ready", {15'd0, in_ready}, 16'd1);
    tick();
    checkOutput("first_out_data", out_data, 16'h04E8);
    checkOutput("first_out_valid", {15'd0, out_valid}, 16'd1);
    checkOutput("first_word_count", word_count, 16'd1);
    checkOutput("first_lfsr", dut.lfsr, 16'h59C3);

    // Back-pressure: next word must wait and keep key 59C3
    in_data   = 16'hABD0;
    out_ready = 1'b0;
    #1;
    checkOutput("bp_in_ready", {15'd0, in_ready}, 16'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_out_data", out_data, 16'h04E8);
      checkOutput("bp_out_valid", {15'd0, out_valid}, 16'd1);
      checkOutput("bp_lfsr", dut.lfsr, 16'h59C3);
      checkOutput("bp_word_count", word_count, 16'd1);
    end

    // Release: drain and accept in the same cycle
    out_ready = 1'b1;
    #1;
    checkOutput("release_in_ready", {15'd0, in_ready}, 16'd1);
    tick();
    checkOutput("second_out_data", out_data, 16'h0DEC);
    checkOutput("second_word_count", word_count, 16'd2);
    checkOutput("second_lfsr", dut.lfsr, 16'hB387);
    checkOutput("b2b_in_ready", {15'd0, in_ready}, 16'd1);

    // Back-to-back third word with key B387
    in_data = 16'h1234;
    tick();
    checkOutput("third_out_data", out_data, 16'h5E4C);
    checkOutput("third_word_count", word_count, 16'd3);
    checkOutput("third_out_valid", {15'd0, out_valid}, 16'd1);

    // Asynchronous reset mid-stream, away from any clock edge
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid", {15'd0, out_valid}, 16'd0);
    checkOutput("async_out_data", out_data, 16'h0000);
    checkOutput("async_word_count", word_count, 16'd0);
    checkOutput("async_lfsr", dut.lfsr, 16'hACE1);
    @(negedge clk);
    rst_n = 1'b1;

    // Advance the keystream, then load a zero seed alongside a valid word
    in_valid = 1'b1;
    in_data  = 16'h57F6;
    tick();
    checkOutput("pre_seed_out_data", out_data, 16'h04E8);
    seed_load = 1'b1;
    seed_in   = 16'h0000;
    #1;
    checkOutput("seed_in_ready", {15'd0, in_ready}, 16'd0);
    tick();
    seed_load = 1'b0;
    checkOutput("seed_zero_lfsr", dut.lfsr, 16'hACE1);
    checkOutput("seed_zero_count", word_count, 16'd0);
    checkOutput("seed_drain_valid", {15'd0, out_valid}, 16'd0);
    checkOutput("seed_drain_hold", out_data, 16'h04E8);
    tick();
    checkOutput("post_seed_out_data", out_data, 16'h04E8);
    checkOutput("post_seed_count", word_count, 16'd1);

    // Nonzero seed is loaded as given
    in_valid  = 1'b0;
    seed_load = 1'b1;
    seed_in   = 16'h59C3;
    tick();
    seed_load = 1'b0;
    checkOutput("seed_val_lfsr", dut.lfsr, 16'h59C3);
    in_valid = 1'b1;
    in_data  = 16'hABD0;
    tick();
    checkOutput("seed_val_out_data", out_data, 16'h0DEC);
    checkOutput("seed_val_count", word_count, 16'd1);
    in_valid = 1'b0;
    tick();
    checkOutput("idle_out_valid", {15'd0, out_valid}, 16'd0);
    checkOutput("idle_count", word_count, 16'd1);

`ifdef XNOR_DESCRAMBLE_BYPASS_EN
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n    = 1'b1;
    bypass   = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h1234;
    tick();
    checkOutput("bypass_out_data", out_data, 16'h1234);
    checkOutput("bypass_lfsr", dut.lfsr, 16'hACE1);
    checkOutput("bypass_count", word_count, 16'd1);
    bypass  = 1'b0;
    in_data = 16'h57F6;
    tick();
    checkOutput("unbypass_out_data", out_data, 16'h04E8);
    in_valid = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
